alu_decode: RTL and testbench

ALU_DECODE -- requirements
Module: alu_decode

---
 rtl/alu_decode.sv | 174 +++++++++++++++++
 tb/tb_alu_decode.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode.sv
// RV32I integer-ALU decode stage: a one-entry register slice that turns an instruction word into
// an ALU opcode, operands and writeback controls, and counts illegal instructions it accepts.
module alu_decode #(
    parameter int unsigned CNT_W = 8
) (
`ifdef USE_POWER_PINS
    inout  wire              vccd1,
    inout  wire              vssd1,
`endif
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      pc,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_op,
    output logic [31:0]      in1,
    output logic [31:0]      in2,
    output logic [4:0]       rd_addr,
    output logic             rd_wen,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] OpcLui   = 7'b0110111;
    localparam logic [6:0] OpcAuipc = 7'b0010111;
    localparam logic [6:0] F7Zero   = 7'b0000000;
    localparam logic [6:0] F7Alt    = 7'b0100000;
    localparam logic [3:0] AluAdd   = 4'b0000;
    localparam logic [3:0] AluBad   = 4'b1111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_field;

    assign opcode   = instr[6:0];
    assign rd_field = instr[11:7];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];

    // Decoded fields for the instruction currently presented on the input side.
    logic [3:0]  dec_op;
    logic [31:0] dec_in1;
    logic [31:0] dec_in2;
    logic        dec_illegal;
    logic        dec_wen;

    always_comb begin
        dec_op      = AluBad;
        dec_in1     = 32'h0;
        dec_in2     = 32'h0;
        dec_illegal = 1'b1;
        unique case (opcode)
            OpcOp: begin
                dec_op      = {instr[30], funct3};
                dec_in1     = rs1_data;
                dec_in2     = rs2_data;
                dec_illegal = !((funct7 == F7Zero) ||
                                ((funct7 == F7Alt) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OpcOpImm: begin
                dec_op      = (funct3 == 3'b101) ? {instr[30], 3'b101} : {1'b0, funct3};
                dec_in1     = rs1_data;
                dec_in2     = {{20{instr[31]}}, instr[31:20]};
                if (funct3 == 3'b001) begin
                    dec_illegal = (funct7 != F7Zero);
                end else if (funct3 == 3'b101) begin
                    dec_illegal = !((funct7 == F7Zero) || (funct7 == F7Alt));
                end else begin
                    dec_illegal = 1'b0;
                end
            end
            OpcLui: begin
                dec_op      = AluAdd;
                dec_in1     = 32'h0;
                dec_in2     = {instr[31:12], 12'h000};
                dec_illegal = 1'b0;
            end
            OpcAuipc: begin
                dec_op      = AluAdd;
                dec_in1     = pc;
                dec_in2     = {instr[31:12], 12'h000};
                dec_illegal = 1'b0;
            end
            default: ;
        endcase
        // Illegal encodings must present a canonical, side-effect-free slot.
        if (dec_illegal) begin
            dec_op  = AluBad;
            dec_in1 = 32'h0;
            dec_in2 = 32'h0;
        end
        dec_wen = !dec_illegal && (rd_field != 5'd0);
    end

    logic             out_valid_q, out_valid_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [31:0]      in1_q, in1_d;
    logic [31:0]      in2_q, in2_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic             rd_wen_q, rd_wen_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_xfer;
    logic             out_xfer;

    assign in_ready = !out_valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        alu_op_d    = alu_op_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        rd_addr_d   = rd_addr_q;
        rd_wen_d    = rd_wen_q;
        illegal_d   = illegal_q;
        cnt_d       = cnt_q;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            alu_op_d    = dec_op;
            in1_d       = dec_in1;
            in2_d       = dec_in2;
            rd_addr_d   = rd_field;
            rd_wen_d    = dec_wen;
            illegal_d   = dec_illegal;
            if (dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            alu_op_q    <= 4'h0;
            in1_q       <= 32'h0;
            in2_q       <= 32'h0;
            rd_addr_q   <= 5'h0;
            rd_wen_q    <= 1'b0;
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_op_q    <= alu_op_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            rd_addr_q   <= rd_addr_d;
            rd_wen_q    <= rd_wen_d;
            illegal_q   <= illegal_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_op      = alu_op_q;
    assign in1         = in1_q;
    assign in2         = in2_q;
    assign rd_addr     = rd_addr_q;
    assign rd_wen      = rd_wen_q;
    assign illegal     = illegal_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_decode.sv
// Directed bench for alu_decode: hand-computed vectors checked with immediate assertions.
module tb_alu_decode;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [4:0]  rd_addr;
    logic        rd_wen;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    int n_pass  = 0;
    int n_total = 0;

    alu_decode #(.CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .pc          (pc),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_op      (alu_op),
        .in1         (in1),
        .in2         (in2),
        .rd_addr     (rd_addr),
        .rd_wen      (rd_wen),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
        in_valid = 1'b1;
        instr    = i;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = 32'h0;
        pc        = 32'h0;
        rs1_data  = 32'h0;
        rs2_data  = 32'h0;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_in1", in1, 32'd0);
        check("rst_cnt", 32'(illegal_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // ADD x3,x1,x2
        drive(32'h002081B3, 32'd5, 32'd7);
        tick();
        in_valid = 1'b0;
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_op", 32'(alu_op), 32'h0);
        check("add_in1", in1, 32'd5);
        check("add_in2", in2, 32'd7);
        check("add_rd", 32'(rd_addr), 32'd3);
        check("add_wen", 32'(rd_wen), 32'd1);
        check("add_ill", 32'(illegal), 32'd0);
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);

        // SRAI x5,x6,4 then ADDI x1,x0,-1 back to back
        drive(32'h40435293, 32'h80000000, 32'd0);
        tick();
        check("srai_op", 32'(alu_op), 32'hD);
        check("srai_in1", in1, 32'h80000000);
        check("srai_in2", in2, 32'h00000404);
        check("srai_wen", 32'(rd_wen), 32'd1);
        check("srai_rd", 32'(rd_addr), 32'd5);
        drive(32'hFFF00093, 32'd0, 32'd0);
        tick();
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_op", 32'(alu_op), 32'h0);
        check("addi_in2", in2, 32'hFFFFFFFF);
        check("addi_rd", 32'(rd_addr), 32'd1);

        // AUIPC x1,0x12345 at pc 0x100
        pc = 32'h100;
        drive(32'h12345097, 32'hDEADBEEF, 32'd0);
        tick();
        check("auipc_op", 32'(alu_op), 32'h0);
        check("auipc_in1", in1, 32'h100);
        check("auipc_in2", in2, 32'h12345000);

        // LUI x2,0x12345
        drive(32'h12345137, 32'hDEADBEEF, 32'd0);
        tick();
        check("lui_in1", in1, 32'h0);
        check("lui_in2", in2, 32'h12345000);
        check("lui_rd", 32'(rd_addr), 32'd2);

        // ADD x0,x1,x2: legal but no writeback
        drive(32'h00208033, 32'd1, 32'd2);
        tick();
        check("x0_wen", 32'(rd_wen), 32'd0);
        check("x0_ill", 32'(illegal), 32'd0);

        // SUB x3,x1,x2
        drive(32'h402081B3, 32'd9, 32'd4);
        tick();
        check("sub_op", 32'(alu_op), 32'h8);
        check("sub_in2", in2, 32'd4);
        check("cnt_legal", 32'(illegal_cnt), 32'd0);

        // Backpressure: A accepted, then B and C wait behind a 2-cycle stall
        drive(32'h002081B3, 32'd5, 32'd7);
        tick();
        out_ready = 1'b0;
        drive(32'h40208233, 32'd5, 32'd7);
        #1;
        check("bp_in_ready0", 32'(in_ready), 32'd0);
        tick();
        check("bp_hold1_rd", 32'(rd_addr), 32'd3);
        check("bp_hold1_op", 32'(alu_op), 32'h0);
        check("bp_hold1_vld", 32'(out_valid), 32'd1);
        tick();
        check("bp_hold2_rd", 32'(rd_addr), 32'd3);
        check("bp_hold2_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready1", 32'(in_ready), 32'd1);
        tick();
        check("bp_b_rd", 32'(rd_addr), 32'd4);
        check("bp_b_op", 32'(alu_op), 32'h8);
        drive(32'h0020C2B3, 32'd5, 32'd7);
        tick();
        in_valid = 1'b0;
        check("bp_c_rd", 32'(rd_addr), 32'd5);
        check("bp_c_op", 32'(alu_op), 32'h4);
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Illegal instructions
        drive(32'h00000000, 32'd3, 32'd3);
        tick();
        check("ill0_flag", 32'(illegal), 32'd1);
        check("ill0_op", 32'(alu_op), 32'hF);
        check("ill0_wen", 32'(rd_wen), 32'd0);
        check("ill0_in1", in1, 32'd0);
        check("ill0_cnt", 32'(illegal_cnt), 32'd1);
        drive(32'h40109093, 32'd3, 32'd3);
        tick();
        check("slli_flag", 32'(illegal), 32'd1);
        check("slli_op", 32'(alu_op), 32'hF);
        check("slli_wen", 32'(rd_wen), 32'd0);
        check("slli_cnt", 32'(illegal_cnt), 32'd2);
        drive(32'h402091B3, 32'd3, 32'd3);
        tick();
        check("rill_flag", 32'(illegal), 32'd1);
        check("rill_cnt", 32'(illegal_cnt), 32'd3);
        for (int i = 0; i < 251; i++) tick();
        check("cnt_254", 32'(illegal_cnt), 32'd254);
        tick();
        check("cnt_255", 32'(illegal_cnt), 32'd255);
        for (int i = 0; i < 45; i++) tick();
        check("cnt_sat", 32'(illegal_cnt), 32'd255);
        in_valid = 1'b0;
        tick();

        // Asynchronous reset with a stalled slot
        drive(32'h002081B3, 32'd5, 32'd7);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_cnt", 32'(illegal_cnt), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_rd", 32'(rd_addr), 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post_rst_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
